// File: rtl/timer_pkg.sv
// Shared constants, FSM state types and byte-strobe helpers for the AXI4 timer responder.
// Register offsets are decoded on address bits [4:0] only.
package timer_pkg;

  localparam logic [4:0] OFF_CNT_LO = 5'h00;
  localparam logic [4:0] OFF_CNT_HI = 5'h04;
  localparam logic [4:0] OFF_CMP_LO = 5'h08;
  localparam logic [4:0] OFF_CMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL   = 5'h10;
  localparam logic [4:0] OFF_STATUS = 5'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  function automatic logic addr_err(input logic [4:0] off);
    return (off > OFF_STATUS) || (off[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/timer_regs.sv
// Timer register file: prescaled 64-bit counter, compare, control, status and interrupt.
// Reads are combinational; writes and counting take effect on the clock edge.
module timer_regs
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_raddr,
  output logic [31:0] o_rdata,
  output logic        o_rerr,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_werr,
  output logic        o_irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [63:0]   r_cnt;
  logic [63:0]   r_cmp;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_ctrl;
  logic          r_pending;
  logic          r_irq;

  logic [63:0]   w_cnt_next;
  logic [63:0]   w_cmp_next;
  logic [PW-1:0] w_pre_next;
  logic [1:0]    w_ctrl_next;
  logic          w_pending_next;
  logic          w_inc;
  logic          w_set;
  logic          w_clr;

  always_comb begin
    w_inc       = r_ctrl[0] && (r_pre == PRE_MAX);
    w_pre_next  = r_pre;
    if (r_ctrl[0]) begin
      w_pre_next = w_inc ? '0 : r_pre + PW'(1);
    end
    w_cnt_next  = w_inc ? r_cnt + 64'd1 : r_cnt;
    w_cmp_next  = r_cmp;
    w_ctrl_next = r_ctrl;
    w_clr       = 1'b0;
    // A bus write to a counter half overrides that half's increment.
    if (i_we) begin
      case (i_waddr)
        OFF_CNT_LO: w_cnt_next[31:0]  = byte_merge(r_cnt[31:0], i_wdata, i_wstrb);
        OFF_CNT_HI: w_cnt_next[63:32] = byte_merge(r_cnt[63:32], i_wdata, i_wstrb);
        OFF_CMP_LO: w_cmp_next[31:0]  = byte_merge(r_cmp[31:0], i_wdata, i_wstrb);
        OFF_CMP_HI: w_cmp_next[63:32] = byte_merge(r_cmp[63:32], i_wdata, i_wstrb);
        OFF_CTRL:   w_ctrl_next       = i_wstrb[0] ? i_wdata[1:0] : r_ctrl;
        OFF_STATUS: w_clr             = i_wstrb[0] & i_wdata[0];
        default:    ;
      endcase
    end
    w_set          = r_ctrl[0] && (r_cnt >= r_cmp);
    w_pending_next = w_set | (r_pending & ~w_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_cmp     <= '1;
      r_pre     <= '0;
      r_ctrl    <= '0;
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_cmp     <= w_cmp_next;
      r_pre     <= w_pre_next;
      r_ctrl    <= w_ctrl_next;
      r_pending <= w_pending_next;
      r_irq     <= r_pending & r_ctrl[1];
    end
  end

  always_comb begin
    o_rerr = addr_err(i_raddr);
    case (i_raddr)
      OFF_CNT_LO: o_rdata = r_cnt[31:0];
      OFF_CNT_HI: o_rdata = r_cnt[63:32];
      OFF_CMP_LO: o_rdata = r_cmp[31:0];
      OFF_CMP_HI: o_rdata = r_cmp[63:32];
      OFF_CTRL:   o_rdata = {30'd0, r_ctrl};
      OFF_STATUS: o_rdata = {31'd0, r_pending};
      default:    o_rdata = 32'd0;
    endcase
  end

  assign o_werr = addr_err(i_waddr);
  assign o_irq  = r_irq;

endmodule

// File: rtl/axi4_timer_slave.sv
// AXI4 responder for the timer: independent read and write channel FSMs in front of timer_regs.
// Burst-level errors (bad size, WRAP, bad start address) make every beat of the burst SLVERR.
module axi4_timer_slave
  import timer_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [31:0]         ar_addr,
  input  logic [ID_WIDTH-1:0] ar_id,
  input  logic [7:0]          ar_len,
  input  logic [2:0]          ar_size,
  input  logic [1:0]          ar_burst,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [31:0]         rd_data,
  output logic [ID_WIDTH-1:0] rd_id,
  output logic [1:0]          rd_resp,
  output logic                rd_last,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [31:0]         aw_addr,
  input  logic [ID_WIDTH-1:0] aw_id,
  input  logic [7:0]          aw_len,
  input  logic [2:0]          aw_size,
  input  logic [1:0]          aw_burst,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [31:0]         wd_data,
  input  logic [3:0]          wstrb,
  input  logic                wd_last,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [1:0]          wr_breap,
  output logic [ID_WIDTH-1:0] wr_id,
  output logic                irq
);

  rd_state_t           r_rstate, w_rstate_next;
  logic [4:0]          r_raddr;
  logic [ID_WIDTH-1:0] r_rid;
  logic [7:0]          r_rlen;
  logic [7:0]          r_rcnt;
  logic [1:0]          r_rburst;
  logic                r_rberr;
  logic [31:0]         r_rd_data;
  logic [1:0]          r_rd_resp;

  wr_state_t           r_wstate, w_wstate_next;
  logic [4:0]          r_waddr;
  logic [ID_WIDTH-1:0] r_wid;
  logic [1:0]          r_wburst;
  logic                r_wberr;
  logic                r_werr_any;

  logic        w_ar_hs, w_rd_hs, w_aw_hs, w_wd_hs, w_wr_hs;
  logic        w_rd_last_beat;
  logic [4:0]  w_raddr_adv;
  logic [4:0]  w_reg_raddr;
  logic        w_ar_berr, w_aw_berr;
  logic        w_beat_rerr, w_beat_werr;
  logic [31:0] w_rdata;
  logic        w_rerr, w_werr;
  logic        w_reg_we;
  logic        w_unused;

  assign w_unused = ^{ar_addr[31:5], aw_addr[31:5], aw_len};

  assign w_ar_hs        = ar_valid & ar_ready;
  assign w_rd_hs        = rd_valid & rd_ready;
  assign w_aw_hs        = aw_valid & aw_ready;
  assign w_wd_hs        = wd_valid & wd_ready;
  assign w_wr_hs        = wr_valid & wr_ready;
  assign w_rd_last_beat = (r_rcnt == r_rlen);
  assign w_raddr_adv    = (r_rburst == BURST_INCR) ? r_raddr + 5'd4 : r_raddr;

  // The register port looks ahead to the beat about to be issued so data is captured at issue.
  assign w_reg_raddr = (r_rstate == R_IDLE) ? ar_addr[4:0] : w_raddr_adv;
  assign w_ar_berr   = (ar_size != SIZE_WORD) | (ar_burst == BURST_WRAP) | addr_err(ar_addr[4:0]);
  assign w_aw_berr   = (aw_size != SIZE_WORD) | (aw_burst == BURST_WRAP) | addr_err(aw_addr[4:0]);
  assign w_beat_rerr = ((r_rstate == R_IDLE) ? w_ar_berr : r_rberr) | w_rerr;
  assign w_beat_werr = r_wberr | w_werr;
  assign w_reg_we    = w_wd_hs & ~w_beat_werr;

  timer_regs #(
    .PRESCALE (PRESCALE)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .i_raddr (w_reg_raddr),
    .o_rdata (w_rdata),
    .o_rerr  (w_rerr),
    .i_we    (w_reg_we),
    .i_waddr (r_waddr),
    .i_wdata (wd_data),
    .i_wstrb (wstrb),
    .o_werr  (w_werr),
    .o_irq   (irq)
  );

  always_ff @(posedge clk) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_next;
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
      R_DATA:  if (w_rd_hs && w_rd_last_beat) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = 1'b0;
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    case (r_rstate)
      R_IDLE: ar_ready = ~reset;
      R_DATA: begin
        rd_valid = ~reset;
        rd_last  = ~reset & w_rd_last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_raddr   <= '0;
      r_rid     <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rburst  <= '0;
      r_rberr   <= 1'b0;
      r_rd_data <= '0;
      r_rd_resp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_raddr   <= ar_addr[4:0];
      r_rid     <= ar_id;
      r_rlen    <= ar_len;
      r_rcnt    <= '0;
      r_rburst  <= ar_burst;
      r_rberr   <= w_ar_berr;
      r_rd_data <= w_beat_rerr ? 32'd0 : w_rdata;
      r_rd_resp <= w_beat_rerr ? RESP_SLVERR : RESP_OKAY;
    end else if (w_rd_hs && !w_rd_last_beat) begin
      r_raddr   <= w_raddr_adv;
      r_rcnt    <= r_rcnt + 8'd1;
      r_rd_data <= w_beat_rerr ? 32'd0 : w_rdata;
      r_rd_resp <= w_beat_rerr ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign rd_data = r_rd_data;
  assign rd_resp = r_rd_resp;
  assign rd_id   = r_rid;

  always_ff @(posedge clk) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_next;
  end

  // wd_last alone ends the burst; aw_len is deliberately not tracked.
  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_next = W_DATA;
      W_DATA:  if (w_wd_hs && wd_last) w_wstate_next = W_RESP;
      W_RESP:  if (w_wr_hs) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = 1'b0;
    wd_ready = 1'b0;
    wr_valid = 1'b0;
    case (r_wstate)
      W_IDLE:  aw_ready = ~reset;
      W_DATA:  wd_ready = ~reset;
      W_RESP:  wr_valid = ~reset;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_waddr    <= '0;
      r_wid      <= '0;
      r_wburst   <= '0;
      r_wberr    <= 1'b0;
      r_werr_any <= 1'b0;
    end else if (w_aw_hs) begin
      r_waddr    <= aw_addr[4:0];
      r_wid      <= aw_id;
      r_wburst   <= aw_burst;
      r_wberr    <= w_aw_berr;
      r_werr_any <= 1'b0;
    end else if (w_wd_hs) begin
      r_waddr    <= (r_wburst == BURST_INCR) ? r_waddr + 5'd4 : r_waddr;
      r_werr_any <= r_werr_any | w_beat_werr;
    end
  end

  assign wr_breap = r_werr_any ? RESP_SLVERR : RESP_OKAY;
  assign wr_id    = r_wid;

endmodule
